sub_bytes_engine: RTL and testbench
===================================

# sub_bytes_engine

Parametrised, sequential AES SubBytes / InvSubBytes engine for the 128-bit AES state. It trades area for latency by instantiating only `LANES` S-box pairs and iterating over the 16 state bytes. It offers a per-block forward/inverse mode and valid/ready handshakes on both sides. It sits between the round-key/ShiftRows datapath and the round controller, replacing the fully parallel 16-S-box SubBytes where area matters.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration `$error`.
- `INV_EN`, default 1: 1 instantiates the inverse S-boxes; 0 omits them and forces `Inverse` to be ignored (forward only).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `InValid`  in  1  `DataIn`/`Inverse` valid.
- `InReady`  out  1  engine can accept a block.
- `DataIn`  in  128  AES state. Byte i = `DataIn[127-8i -: 8]`; byte 0 is the MSB byte.
- `Inverse`  in  1  1 = InvSubBytes, 0 = SubBytes. Sampled with `DataIn`.
- `OutValid`  out  1  `DataOut` holds a finished block.
- `OutReady`  in  1  consumer accepts `DataOut`.
- `DataOut`  out  128  substituted state, same byte order as `DataIn`.
- `Busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Submodules:** `LANES` instances of `SBox` (ports `a`, `d`). When `INV_EN`=1, also `LANES` instances of `InvSBox` with the same port shape; `InvSBox` is combinational and is delivered with this block.
- **Cycle count:** N = 16/`LANES` substitution cycles per block.
- **Working state:** 128-bit register `work`, mode flag `mode_q`, and counter `idx` of width max(1, log2 N).
- **State machine, IDLE → RUN:**
  - IDLE: `InReady`=1.
  - On `InValid && InReady`, load `work` ← `DataIn`, `mode_q` ← `Inverse && INV_EN`, `idx` ← 0, then go to RUN.
- **RUN:**
  - Each cycle, bytes `idx*LANES` … `idx*LANES+LANES-1` of `work` are replaced by their S-box outputs; `mode_q` selects `SBox` or `InvSBox`. All other bytes are held.
  - `idx` increments each cycle.
  - In the cycle where `idx` = N-1, go to DONE.
- **DONE:**
  - `OutValid`=1 and `DataOut`=`work`.
  - On `OutValid && OutReady`:
    - If `InValid` is also high, load the new block and go to RUN (back-to-back).
    - Otherwise go to IDLE.
- **`InReady` rule:** `InReady` = IDLE | (DONE & `OutReady`). It is combinational from `OutReady`; there is no combinational path from `InValid` to `InReady`.
- **DONE hold:** while `OutReady`=0 in DONE, `DataOut` stays stable and new inputs are refused.
- **Output outside DONE:** `DataOut` is driven from `work` at all times, so intermediate values are visible. Consumers use it only when `OutValid`=1.
- **Mode per block:** `Inverse` changing mid-block has no effect; mode is latched at accept.
- **`LANES`=16:** N=1, so RUN lasts one cycle and `idx` is unused. This must still be functionally identical to the other widths.

## Timing
- **Reset values:** `InReady`=1, `OutValid`=0, `Busy`=0, `DataOut`=0, state=IDLE, `idx`=0, `mode_q`=0.
- **Accept to `OutValid`:** exactly N+1 rising edges after the accept edge (1 load + N substitutions). For example: `LANES`=4 gives 5 edges; `LANES`=16 gives 2 edges; `LANES`=1 gives 17 edges.
- **Throughput:** with `OutReady` tied high and `InValid` continuous, one block every N+1 cycles.
- **Reset mid-operation:** `rst_n` low at any time immediately clears all state, with no clock required. Any in-flight block is discarded and no `OutValid` pulse follows.
- **Output ordering:** blocks complete in acceptance order; there is only ever one block in flight.

## Test plan
- **Forward, FIPS-197 round-1 state, `LANES`=4:** `DataIn`=193de3bea0f4e22b9ac68d2ae9f84808, `Inverse`=0. Required: `DataOut`=d42711aee0bf98f1b8b45de51e415230, with `OutValid` rising 5 edges after accept.
- **Inverse of the previous result:** `DataIn`=d42711aee0bf98f1b8b45de51e415230, `Inverse`=1. Required: 193de3bea0f4e22b9ac68d2ae9f84808. Repeat for `LANES` ∈ {1, 2, 8, 16} and check latencies of 17, 9, 3 and 2 edges respectively.
- **Spot bytes:** all-zero state, forward → 16×63. State 16×53, forward → 16×ed. State 16×63, inverse → all-zero.
- **Backpressure:** hold `OutReady`=0 for 10 cycles in DONE. Required: `DataOut` stable, `InReady`=0, and a pending `InValid` is not accepted. When `OutReady` is released while `InValid`=1, the next block is accepted on the same edge.
- **Mode latching / `INV_EN`=0:** toggle `Inverse` during RUN; the result must match the mode at accept. With `INV_EN`=0 and `Inverse`=1, the output must be the forward SubBytes result.
- **Async reset:** assert `rst_n`=0 mid-RUN between clock edges. Required: `OutValid`=0, `Busy`=0 and `InReady`=1 immediately. After release, a fresh block completes with the correct value.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes / InvSubBytes engine: LANES S-box pairs iterate over the 16 state bytes.
// Also holds the combinational SBox and InvSBox lookups it instantiates.

module SBox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  localparam logic [0:255][7:0] Table = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign d = Table[a];
endmodule

module InvSBox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  localparam logic [0:255][7:0] Table = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign d = Table[a];
endmodule

module sub_bytes_engine #(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_data_in,
  input  logic         i_inverse,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_data_out,
  output logic         o_busy
);
  localparam int N     = 16 / int'(LANES);
  localparam int IdxW  = (N > 1) ? $clog2(N) : 1;
  localparam int LaneW = 8 * int'(LANES);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   r_state;
  // Work register grouped so that group g holds bytes g*LANES .. g*LANES+LANES-1, MSB first.
  logic [0:N-1][LaneW-1:0]  r_work;
  logic                     r_mode;
  logic [IdxW-1:0]          r_idx;

  logic [LaneW-1:0]         w_group;
  logic [LaneW-1:0]         w_sub;
  logic [0:N-1][LaneW-1:0]  w_work_next;
  logic                     w_in_ready;
  logic                     w_accept;

  always_comb begin
    w_group = '0;
    for (int g = 0; g < N; g++) begin
      if (r_idx == IdxW'(g)) w_group = r_work[g];
    end
  end

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [7:0] w_in, w_fwd, w_inv;
    assign w_in = w_group[LaneW-1-8*l -: 8];
    SBox u_sbox (.a(w_in), .d(w_fwd));
    if (INV_EN) begin : g_inv
      InvSBox u_inv_sbox (.a(w_in), .d(w_inv));
    end else begin : g_no_inv
      assign w_inv = w_fwd;  // r_mode can never be set in this build
    end
    assign w_sub[LaneW-1-8*l -: 8] = r_mode ? w_inv : w_fwd;
  end

  always_comb begin
    w_work_next = r_work;
    for (int g = 0; g < N; g++) begin
      if (r_idx == IdxW'(g)) w_work_next[g] = w_sub;
    end
  end

  assign w_in_ready = (r_state == StIdle) || ((r_state == StDone) && i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StRun: begin
          r_work <= w_work_next;
          if (r_idx == IdxW'(N - 1)) begin
            r_idx   <= '0;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        StDone: if (i_out_ready && !i_in_valid) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
      // Accept overrides the above, covering both IDLE and the back-to-back DONE case.
      if (w_accept) begin
        r_work  <= i_data_in;
        r_mode  <= i_inverse && INV_EN;
        r_idx   <= '0;
        r_state <= StRun;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state != StIdle);
  assign o_data_out  = r_work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Table-driven bench for sub_bytes_engine: five LANES widths plus a forward-only build run in lockstep.

module tb_sub_bytes_engine;
  localparam int NumDut = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, inverse, out_ready;
  logic [127:0] data_in;
  logic         w_ir   [NumDut];
  logic         w_ov   [NumDut];
  logic         w_busy [NumDut];
  logic [127:0] w_do   [NumDut];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Instances 0..4: LANES = 1,2,4,8,16 with inverse S-boxes.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << g), .INV_EN(1'b1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(w_ir[g]),
      .i_data_in(data_in), .i_inverse(inverse), .o_out_valid(w_ov[g]),
      .i_out_ready(out_ready), .o_data_out(w_do[g]), .o_busy(w_busy[g])
    );
  end

  // Instance 5: forward-only build.
  sub_bytes_engine #(.LANES(4), .INV_EN(1'b0)) u_dut_fwd (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(w_ir[5]),
    .i_data_in(data_in), .i_inverse(inverse), .o_out_valid(w_ov[5]),
    .i_out_ready(out_ready), .o_data_out(w_do[5]), .o_busy(w_busy[5])
  );

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic         toggle;
    logic [127:0] exp;
    logic [127:0] exp_fwd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  function automatic int exp_lat(input int i);
    return (i == 5) ? 5 : (16 / (1 << i)) + 1;
  endfunction

  // Latency counts edges with the accept edge as edge 1.
  task automatic run_block(input vec_t v, input int vi);
    int           lat[NumDut];
    logic [127:0] got[NumDut];
    @(negedge clk);
    data_in = v.din; inverse = v.inv; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = ~v.din;
    for (int i = 0; i < NumDut; i++) begin lat[i] = 0; got[i] = '0; end
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < NumDut; i++) begin
        if (lat[i] == 0 && w_ov[i]) begin lat[i] = c; got[i] = w_do[i]; end
      end
      if (v.toggle) inverse = ~inverse;
      @(negedge clk);
    end
    for (int i = 0; i < NumDut; i++) begin
      chk($sformatf("v%0d dut%0d latency", vi, i), 128'(lat[i]), 128'(exp_lat(i)));
      chk($sformatf("v%0d dut%0d data", vi, i), got[i], (i == 5) ? v.exp_fwd : v.exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inverse = 1'b0; data_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] fips_in, fips_out, z, s53, s63, sed, sfb;
    int           lat;
    int           seen;
    fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
    z   = '0;
    s53 = {16{8'h53}};
    s63 = {16{8'h63}};
    sed = {16{8'hed}};
    sfb = {16{8'hfb}};
    vecs[0] = '{din: fips_in,  inv: 1'b0, toggle: 1'b0, exp: fips_out, exp_fwd: fips_out};
    vecs[1] = '{din: fips_out, inv: 1'b1, toggle: 1'b0, exp: fips_in,
                exp_fwd: 128'h48cc82e4e10846a16c8d4cd972830004};
    vecs[2] = '{din: z,        inv: 1'b0, toggle: 1'b0, exp: s63, exp_fwd: s63};
    vecs[3] = '{din: s53,      inv: 1'b0, toggle: 1'b0, exp: sed, exp_fwd: sed};
    vecs[4] = '{din: s63,      inv: 1'b1, toggle: 1'b0, exp: z,   exp_fwd: sfb};
    vecs[5] = '{din: fips_out, inv: 1'b1, toggle: 1'b1, exp: fips_in,
                exp_fwd: 128'h48cc82e4e10846a16c8d4cd972830004};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inverse = 1'b0; data_in = '0;
    #1;
    for (int i = 0; i < NumDut; i++) begin
      chk($sformatf("reset dut%0d in_ready", i), 128'(w_ir[i]), 128'(1));
      chk($sformatf("reset dut%0d out_valid", i), 128'(w_ov[i]), 128'(0));
      chk($sformatf("reset dut%0d busy", i), 128'(w_busy[i]), 128'(0));
      chk($sformatf("reset dut%0d data", i), w_do[i], z);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_block(vecs[v], v);

    // Backpressure on the LANES=4 instance.
    do_reset();
    @(negedge clk);
    data_in = z; inverse = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (w_ov[2]) seen = 1;
      else @(negedge clk);
    end
    chk("bp reached done", 128'(seen), 128'(1));
    data_in = s53; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp hold%0d data", k), w_do[2], s63);
      chk($sformatf("bp hold%0d in_ready", k), 128'(w_ir[2]), 128'(0));
      chk($sformatf("bp hold%0d out_valid", k), 128'(w_ov[2]), 128'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 128'(w_ir[2]), 128'(1));
    @(negedge clk);
    chk("bp accept busy", 128'(w_busy[2]), 128'(1));
    chk("bp accept out_valid", 128'(w_ov[2]), 128'(0));
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (lat == 0 && w_ov[2]) begin
        lat = c;
        chk("bp second data", w_do[2], sed);
      end
      @(negedge clk);
    end
    chk("bp second latency", 128'(lat), 128'(5));

    // Asynchronous reset between edges while running.
    do_reset();
    @(negedge clk);
    data_in = fips_in; inverse = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset out_valid", 128'(w_ov[2]), 128'(0));
    chk("areset busy", 128'(w_busy[2]), 128'(0));
    chk("areset in_ready", 128'(w_ir[2]), 128'(1));
    chk("areset data", w_do[2], z);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (w_ov[2]) seen++;
      @(negedge clk);
    end
    chk("areset no stray out_valid", 128'(seen), 128'(0));
    run_block(vecs[0], 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
